// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_e;

   localparam logic       I2C_ACK             = 1'b0;
   localparam logic       I2C_NACK            = 1'b1;
   localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one asynchronous I2C line plus a history flop for edge detection.
module i2c_line_sync #(
   parameter int SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SyncStages-1:0] sync_q;
   logic                  hist_q;

   // Reset to 1 so an idle (pulled-up) bus never looks like an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], line_i};
         hist_q <= sync_q[SyncStages-1];
      end
   end

   assign level_o = sync_q[SyncStages-1];
   assign rise_o  = level_o & ~hist_q;
   assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: first written byte sets the pointer,
// further bytes write registers; reads stream registers with auto-increment.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TargetAddr = DEFAULT_TARGET_ADDR,
   parameter int         NumRegs    = 16,
   parameter int         SyncStages = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       scl_i,
   input  logic                       sda_i,
   output logic                       sda_o,
   output logic                       sda_en_o,
   output logic [NumRegs*8-1:0]       regs_o,
   output logic                       wr_pulse_o,
   output logic [$clog2(NumRegs)-1:0] wr_idx_o,
   output logic                       busy_o
);

   localparam int PW = $clog2(NumRegs);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_sync #(.SyncStages(SyncStages)) u_scl_sync (
      .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i),
      .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_sync #(.SyncStages(SyncStages)) u_sda_sync (
      .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_i),
      .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            rw_q, rw_d;
   logic            first_q, first_d;
   logic            sda_en_q, sda_en_d;
   logic            wr_en;
   logic            wr_pulse_q;
   logic [PW-1:0]   wr_idx_q;
   logic [7:0]      regs_q [NumRegs];

   logic            start_det, stop_det, last_bit;
   logic [7:0]      byte_in, rd_byte;

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;
   assign last_bit  = (bit_cnt_q == 3'd7);
   assign byte_in   = {shift_q[6:0], sda_lvl};
   assign rd_byte   = regs_q[ptr_q];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      first_d   = first_q;
      sda_en_d  = sda_en_q;
      wr_en     = 1'b0;
      if (stop_det) begin
         state_d  = ST_IDLE;
         sda_en_d = 1'b0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd0;
         sda_en_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     if (byte_in[7:1] == TargetAddr) begin
                        state_d = ST_ADDR_ACK;
                        rw_d    = byte_in[0];
                     end else begin
                        state_d = ST_WAIT_STOP;
                     end
                  end
               end
            end
            // First SCL fall drives the ACK, second one releases it and moves on.
            ST_ADDR_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_en_q) begin
                     sda_en_d = ~I2C_ACK;
                  end else begin
                     sda_en_d  = 1'b0;
                     bit_cnt_d = 3'd0;
                     if (state_q == ST_ADDR_ACK && rw_q) begin
                        state_d  = ST_RD_BYTE;
                        shift_d  = rd_byte;
                        sda_en_d = ~rd_byte[7];
                     end else begin
                        state_d = ST_WR_BYTE;
                        if (state_q == ST_ADDR_ACK) first_d = 1'b1;
                     end
                  end
               end
            end
            ST_WR_BYTE: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     state_d = ST_WR_ACK;
                     if (first_q) begin
                        ptr_d   = byte_in[PW-1:0];
                        first_d = 1'b0;
                     end else begin
                        wr_en = 1'b1;
                        ptr_d = ptr_q + PW'(1);
                     end
                  end
               end
            end
            ST_RD_BYTE: begin
               if (scl_fall) begin
                  if (last_bit) begin
                     sda_en_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     sda_en_d  = ~shift_q[6];
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            // Pointer advances on the host ACK; the reload waits for the following fall.
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == I2C_NACK) state_d = ST_WAIT_STOP;
                  else                     ptr_d   = ptr_q + PW'(1);
               end else if (scl_fall) begin
                  state_d   = ST_RD_BYTE;
                  shift_d   = rd_byte;
                  sda_en_d  = ~rd_byte[7];
                  bit_cnt_d = 3'd0;
               end
            end
            default: sda_en_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         sda_en_q   <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_idx_q   <= '0;
         for (int k = 0; k < NumRegs; k++) regs_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         first_q    <= first_d;
         sda_en_q   <= sda_en_d;
         wr_pulse_q <= wr_en;
         if (wr_en) begin
            regs_q[ptr_q] <= byte_in;
            wr_idx_q      <= ptr_q;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NumRegs; gi++) begin : g_regs_out
         assign regs_o[8*gi +: 8] = regs_q[gi];
      end
   endgenerate

   // Release SDA combinationally on STOP or reset, without waiting for the flop.
   assign sda_en_o   = sda_en_q & ~stop_det & ~rst_i;
   assign sda_o      = 1'b0;
   assign wr_pulse_o = wr_pulse_q;
   assign wr_idx_o   = wr_idx_q;
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C host driving the register target, checked against a register/pointer model.
module tb_i2c_target_regs;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         scl = 1'b1;
   logic         sda_m = 1'b1;
   logic         sda_bus;
   logic         sda_o, sda_en_o, wr_pulse_o, busy_o;
   logic [127:0] regs_o;
   logic [3:0]   wr_idx_o;

   assign sda_bus = sda_m & ~sda_en_o;

   i2c_target_regs dut (
      .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_en_o(sda_en_o), .regs_o(regs_o),
      .wr_pulse_o(wr_pulse_o), .wr_idx_o(wr_idx_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] m_regs [16];
   int         m_ptr = 0;
   logic [7:0] wdata [4];
   int         pulse_q[$];
   int         exp_pulses[$];
   logic       sda_en_seen = 1'b0;

   always @(negedge clk) begin
      if (sda_en_o) sda_en_seen = 1'b1;
      if (wr_pulse_o) pulse_q.push_back(int'(wr_idx_o));
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clk_bit(input logic b, output logic rd);
      cyc(1); sda_m = b;
      cyc(7); scl = 1'b1;
      cyc(4); rd = sda_bus;
      cyc(4); scl = 1'b0;
   endtask

   task automatic start_cond();
      cyc(1); sda_m = 1'b1;
      cyc(7); scl = 1'b1;
      cyc(8); sda_m = 1'b0;
      cyc(8); scl = 1'b0;
   endtask

   task automatic stop_cond();
      cyc(1); sda_m = 1'b0;
      cyc(7); scl = 1'b1;
      cyc(8); sda_m = 1'b1;
      cyc(8);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic host_ack, output logic [7:0] d);
      logic r;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b1, r);
         d = {d[6:0], r};
      end
      clk_bit(host_ack, r);
   endtask

   task automatic check_regs(input string tag);
      logic [127:0] exp;
      for (int k = 0; k < 16; k++) exp[8*k +: 8] = m_regs[k];
      check(tag, regs_o, exp);
   endtask

   task automatic check_pulses();
      check("pulse_count", pulse_q.size(), exp_pulses.size());
      for (int i = 0; i < exp_pulses.size() && i < pulse_q.size(); i++)
         check("pulse_idx", pulse_q[i], exp_pulses[i]);
   endtask

   task automatic do_write(input logic [7:0] ptr_byte, input int n);
      logic a;
      pulse_q.delete(); exp_pulses.delete();
      start_cond();
      check("busy_after_start", busy_o, 1'b1);
      write_byte(8'hA0, a); check("wr_addr_ack", a, 1'b0);
      write_byte(ptr_byte, a); check("wr_ptr_ack", a, 1'b0);
      m_ptr = ptr_byte % 16;
      for (int i = 0; i < n; i++) begin
         write_byte(wdata[i], a); check("wr_data_ack", a, 1'b0);
         m_regs[m_ptr] = wdata[i];
         exp_pulses.push_back(m_ptr);
         m_ptr = (m_ptr + 1) % 16;
      end
      stop_cond();
      check("busy_after_stop", busy_o, 1'b0);
      check_pulses();
      check_regs("regs_after_write");
   endtask

   task automatic do_read(input logic [7:0] ptr_byte, input int n);
      logic a;
      logic [7:0] d;
      pulse_q.delete(); exp_pulses.delete();
      start_cond();
      write_byte(8'hA0, a); check("rd_waddr_ack", a, 1'b0);
      write_byte(ptr_byte, a); check("rd_ptr_ack", a, 1'b0);
      m_ptr = ptr_byte % 16;
      start_cond();
      write_byte(8'hA1, a); check("rd_raddr_ack", a, 1'b0);
      for (int i = 0; i < n; i++) begin
         read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
         check("rd_data", d, m_regs[m_ptr]);
         if (i != n - 1) m_ptr = (m_ptr + 1) % 16;
      end
      stop_cond();
      check("rd_busy_after_stop", busy_o, 1'b0);
      check_pulses();
      check_regs("regs_after_read");
   endtask

   initial begin
      logic a;
      for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;

      cyc(4);
      check("reset_regs", regs_o, 128'h0);
      check("reset_sda_en", sda_en_o, 1'b0);
      check("reset_sda_o", sda_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_pulse", wr_pulse_o, 1'b0);
      check("reset_idx", wr_idx_o, 4'd0);
      rst = 1'b0;
      cyc(4);

      wdata[0] = 8'h5A; wdata[1] = 8'hC3;
      do_write(8'h03, 2);
      do_read(8'h03, 2);

      // Address mismatch: the target must stay silent on every byte.
      sda_en_seen = 1'b0;
      pulse_q.delete(); exp_pulses.delete();
      start_cond();
      write_byte(8'hA2, a); check("mismatch_addr_nack", a, 1'b1);
      write_byte(8'h04, a); check("mismatch_b1_nack", a, 1'b1);
      write_byte(8'($urandom), a); check("mismatch_b2_nack", a, 1'b1);
      stop_cond();
      check("mismatch_sda_en_seen", sda_en_seen, 1'b0);
      check_pulses();
      check_regs("mismatch_regs");

      wdata[0] = 8'h11; wdata[1] = 8'h22;
      do_write(8'h0F, 2);
      wdata[0] = 8'($urandom);
      do_write(8'h13, 1);

      // STOP in the middle of a data byte after the pointer is set to 5.
      pulse_q.delete(); exp_pulses.delete();
      start_cond();
      write_byte(8'hA0, a); check("abort_addr_ack", a, 1'b0);
      write_byte(8'h05, a); check("abort_ptr_ack", a, 1'b0);
      for (int i = 0; i < 3; i++) clk_bit(1'($urandom), a);
      stop_cond();
      check("abort_sda_en", sda_en_o, 1'b0);
      check("abort_busy", busy_o, 1'b0);
      check_pulses();
      check_regs("abort_regs");

      for (int t = 0; t < 5; t++) begin
         logic [7:0] p;
         int n;
         p = 8'($urandom);
         n = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) wdata[i] = 8'($urandom);
         do_write(p, n);
         do_read(p, n);
         do_read(8'($urandom), $urandom_range(1, 4));
      end

      // Reset while the address ACK is being driven.
      start_cond();
      for (int i = 7; i >= 0; i--) clk_bit(((8'hA0 >> i) & 8'h01) != 0, a);
      cyc(6);
      check("addr_ack_driven", sda_en_o, 1'b1);
      rst = 1'b1;
      cyc(1);
      check("rst_sda_en", sda_en_o, 1'b0);
      check("rst_regs", regs_o, 128'h0);
      check("rst_busy", busy_o, 1'b0);
      sda_m = 1'b1;
      cyc(2);
      scl = 1'b1;
      cyc(4);
      rst = 1'b0;
      cyc(4);
      for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;

      wdata[0] = 8'($urandom);
      do_write(8'h09, 1);
      do_read(8'h08, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
